riscv_uart_programmer: RTL
==========================

Name: riscv_uart_programmer

Overview:
- UART-side initiator of the UART-programmer (UPG) write interface consumed by the data-cache/IO bridge path.
- Receives a length-prefixed byte stream on a serial RX line and assembles 32-bit little-endian words.
- Issues one single-cycle write per word with an incrementing 14-bit word address.
- Raises done after the last word so the CPU side can leave programming mode.

Parameters:
- CLKS_PER_BIT, 1042, clk cycles per UART bit (10 MHz / 9600 baud); must be >= 4.
- MAX_WORDS, 16384, largest legal word count (2^14).

Ports:
- clk  input  1  system clock (UPG clock domain, 10 MHz nominal)
- rst  input  1  asynchronous, active-high reset
- uart_rx  input  1  serial line, idle high, 8N1, LSB first
- upg_rst_o  output  1  high while no programming session is active (reset through first count byte)
- upg_wen_o  output  1  one-cycle write strobe
- upg_adr_o  output  14  word address of the current write
- upg_dat_o  output  32  write data
- upg_done_o  output  1  session finished; sticky until rst
- upg_err_o  output  1  one-cycle pulse on framing error or illegal count

Behaviour:
- Reset (async, rst=1): upg_rst_o=1, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_err_o=0, FSM=CNT_LO, bit timer=0, byte assembly cleared.
- RX front end:
  - uart_rx passes through a 2-flop synchroniser.
  - A start condition is a synchronised low while the receiver is idle.
  - Start bit is re-checked at CLKS_PER_BIT/2. If it is high there, treat it as a glitch and return to idle, with no error.
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first.
  - The stop bit is sampled one CLKS_PER_BIT after data bit 7.
  - Stop bit = 1: byte_valid pulses one cycle.
  - Stop bit = 0: upg_err_o pulses one cycle, the byte is discarded, and the FSM aborts to CNT_LO.
- Session FSM:
  - CNT_LO: on byte_valid, store count[7:0], drop upg_rst_o to 0, go to CNT_HI.
  - CNT_HI: on byte_valid, store count[15:8].
    - count = 0: go to DONE.
    - count > MAX_WORDS: pulse upg_err_o, set upg_rst_o=1, go to CNT_LO.
    - Otherwise: go to DATA with byte index=0 and word counter=0.
  - DATA: each byte_valid shifts into the word as byte[index] (first byte goes to bits 7:0) and increments index mod 4.
    - When byte index 3 arrives, in the following cycle: upg_dat_o = assembled word, upg_adr_o = word counter[13:0], upg_wen_o = 1 for exactly one cycle.
    - Word counter increments in the cycle after upg_wen_o.
    - upg_adr_o and upg_dat_o hold stable until the next write.
    - When the word counter reaches count, go to DONE.
  - DONE: upg_done_o = 1, upg_rst_o = 1. All further RX bytes are ignored (no writes, no errors). Leave only via rst.
- Latency: upg_wen_o asserts 1 clk after the stop-bit sample of the 4th byte of a word.
- Address is the word index, 0 to MAX_WORDS-1, so it never wraps within a legal session.
- Framing error in DATA aborts the session: earlier writes remain performed, upg_done_o stays 0, and the partial word is dropped.
- rst asserted mid-byte or mid-word aborts immediately: all outputs take reset values on the same edge, with no write strobe.
- Simultaneous events: byte_valid and a write strobe never coincide, because a byte takes >= 10*CLKS_PER_BIT cycles. A stop-bit error in the cycle that would complete a word produces no write.

Test Plan (CLKS_PER_BIT=4 for simulation):
- Send 02 00, then EF BE AD DE, then 78 56 34 12.
  - upg_wen_o pulses twice: (adr 0, dat DEADBEEF), then (adr 1, dat 12345678).
  - upg_done_o rises after the second write; upg_rst_o goes 0 at the first byte and back to 1 at done.
- Send 00 00: no upg_wen_o; upg_done_o=1 one cycle after the second byte; later bytes A5 cause nothing.
- Send 01 41 (count 16641 > 16384): upg_err_o pulses once, upg_rst_o=1, FSM back in CNT_LO.
  - Then 01 00 followed by 11 22 33 44 writes adr 0, dat 44332211.
- Count 2, first word ok, second word's 3rd byte sent with stop bit 0:
  - one write only (adr 0), upg_err_o pulse, upg_done_o stays 0.
- Drive a 1-cycle low glitch on uart_rx while idle: no byte_valid, no error.
- Assert rst during the 2nd byte of word 0 (count 1): all outputs reset asynchronously, no upg_wen_o.
  - A fresh 01 00 01 02 03 04 session then writes adr 0, dat 04030201.

Source files
------------

// File: rtl/riscv_uart_programmer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : riscv_uart_programmer
// Description : UART-side initiator of the UART-programmer write interface.
//               Receives a 16-bit little-endian word count followed by that
//               many 32-bit little-endian words over 8N1 serial, and issues
//               one single-cycle write per word at an incrementing address.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_uart_programmer #(
   parameter int CLKS_PER_BIT = 1042,  // clk cycles per UART bit, >= 4
   parameter int MAX_WORDS    = 16384  // largest legal word count
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic        upg_rst_o,
   output logic        upg_wen_o,
   output logic [13:0] upg_adr_o,
   output logic [31:0] upg_dat_o,
   output logic        upg_done_o,
   output logic        upg_err_o
);

   // Bit timer width; it only has to count to CLKS_PER_BIT-1.
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] c_BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] c_HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]   c_MAX_WORDS = 17'(MAX_WORDS);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      S_CNT_LO = 2'd0,
      S_CNT_HI = 2'd1,
      S_DATA   = 2'd2,
      S_DONE   = 2'd3
   } ses_state_t;

   // Receiver state
   logic            r_rx_meta;
   logic            r_rx_sync;
   rx_state_t       r_rx_state;
   logic [TW-1:0]   r_tmr;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;

   // Session state
   ses_state_t      r_state;
   logic [15:0]     r_count;
   logic [15:0]     r_wcnt;
   logic [1:0]      r_bidx;
   logic [23:0]     r_word;
   logic            r_upg_rst;
   logic            r_wen;
   logic [13:0]     r_adr;
   logic [31:0]     r_dat;
   logic            r_done;
   logic            r_err;

   // Receiver events, valid in the cycle the stop bit is sampled
   logic            w_stop_tick;
   logic            w_byte_valid;
   logic            w_frm_err;
   logic [15:0]     w_count_full;

   assign w_stop_tick  = (r_rx_state == RX_STOP) && (r_tmr == c_BIT_LAST);
   assign w_byte_valid = w_stop_tick && r_rx_sync;
   assign w_frm_err    = w_stop_tick && !r_rx_sync;
   assign w_count_full = {r_shift, r_count[7:0]};

   assign upg_rst_o  = r_upg_rst;
   assign upg_wen_o  = r_wen;
   assign upg_adr_o  = r_adr;
   assign upg_dat_o  = r_dat;
   assign upg_done_o = r_done;
   assign upg_err_o  = r_err;

   // Two-flop synchroniser for the asynchronous serial line (idles high)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= uart_rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   // 8N1 receiver: mid-start recheck, then one sample per bit period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_state <= RX_IDLE;
         r_tmr      <= '0;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'd0;
      end else begin
         case (r_rx_state)
            RX_IDLE: begin
               r_tmr <= '0;
               if (!r_rx_sync) begin
                  r_rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (r_tmr == c_HALF_LAST) begin
                  // A line that is high again by mid-start was only a glitch
                  r_tmr      <= '0;
                  r_bit_idx  <= 3'd0;
                  r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_tmr == c_BIT_LAST) begin
                  r_tmr   <= '0;
                  r_shift <= {r_rx_sync, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
                     r_rx_state <= RX_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_tmr == c_BIT_LAST) begin
                  r_tmr      <= '0;
                  r_rx_state <= RX_IDLE;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            default: begin
               r_rx_state <= RX_IDLE;
               r_tmr      <= '0;
            end
         endcase
      end
   end

   // Session FSM: count bytes, word assembly, write strobes and done/err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_CNT_LO;
         r_count   <= 16'd0;
         r_wcnt    <= 16'd0;
         r_bidx    <= 2'd0;
         r_word    <= 24'd0;
         r_upg_rst <= 1'b1;
         r_wen     <= 1'b0;
         r_adr     <= 14'd0;
         r_dat     <= 32'd0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_wen <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_CNT_LO: begin
               if (w_frm_err) begin
                  r_err <= 1'b1;
               end else if (w_byte_valid) begin
                  r_count[7:0] <= r_shift;
                  r_upg_rst    <= 1'b0;
                  r_state      <= S_CNT_HI;
               end
            end
            S_CNT_HI: begin
               if (w_frm_err) begin
                  r_err     <= 1'b1;
                  r_upg_rst <= 1'b1;
                  r_state   <= S_CNT_LO;
               end else if (w_byte_valid) begin
                  r_count[15:8] <= r_shift;
                  if (w_count_full == 16'd0) begin
                     r_done    <= 1'b1;
                     r_upg_rst <= 1'b1;
                     r_state   <= S_DONE;
                  end else if ({1'b0, w_count_full} > c_MAX_WORDS) begin
                     r_err     <= 1'b1;
                     r_upg_rst <= 1'b1;
                     r_state   <= S_CNT_LO;
                  end else begin
                     r_bidx  <= 2'd0;
                     r_wcnt  <= 16'd0;
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (r_wen) begin
                  // Advance the word counter the cycle after each strobe
                  r_wcnt <= r_wcnt + 16'd1;
                  if (r_wcnt + 16'd1 == r_count) begin
                     r_done    <= 1'b1;
                     r_upg_rst <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end else if (w_frm_err) begin
                  // Abort: earlier writes stand, the partial word is dropped
                  r_err     <= 1'b1;
                  r_upg_rst <= 1'b1;
                  r_state   <= S_CNT_LO;
               end else if (w_byte_valid) begin
                  r_bidx <= r_bidx + 2'd1;
                  case (r_bidx)
                     2'd0: r_word[7:0]   <= r_shift;
                     2'd1: r_word[15:8]  <= r_shift;
                     2'd2: r_word[23:16] <= r_shift;
                     default: begin
                        r_dat <= {r_shift, r_word};
                        r_adr <= r_wcnt[13:0];
                        r_wen <= 1'b1;
                     end
                  endcase
               end
            end
            S_DONE: begin
               // Sticky until reset; received bytes and errors are ignored
               r_done    <= 1'b1;
               r_upg_rst <= 1'b1;
            end
            default: begin
               r_upg_rst <= 1'b1;
               r_state   <= S_CNT_LO;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
